// File: rtl/beam_pkg.sv
// Shared FSM state type and width helpers for the beam direction estimator.
package beam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_CORR    = 3'd2,
        ST_DECIDE  = 3'd3,
        ST_DONE    = 3'd4
    } beam_state_e;

    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Product is 2*data_w; summing frame_len of them needs clog2(frame_len) guard bits.
    function automatic int acc_w_f(input int data_w, input int frame_len);
        return 2 * data_w + clog2_f(frame_len);
    endfunction

    function automatic int lag_w_f(input int max_lag);
        return clog2_f(2 * max_lag + 1) + 1;
    endfunction

endpackage

// File: rtl/beam_xcorr_mac.sv
// Signed multiply-accumulate for one cross-correlation lag; zero_term drops
// products whose partner sample lies outside the frame.
module beam_xcorr_mac
    import beam_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_W      = acc_w_f(16, 16)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  zero_term,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_W-1:0]      acc
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]        acc_q;
    logic signed [ACC_W-1:0]        acc_d;

    always_comb begin
        prod  = $signed(a) * $signed(b);
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (enable && !zero_term) begin
            acc_d = acc_q + {{(ACC_W-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/beam_direction_estimator.sv
// Two-microphone direction-of-arrival estimator: captures a frame, cross-correlates
// over lags -MAX_LAG..+MAX_LAG and reports the peak. Optional BEAM_ENERGY_GATE_EN.
module beam_direction_estimator
    import beam_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int FRAME_LEN     = 16,
    parameter int MAX_LAG       = 3,
    parameter int LED_W         = 8,
    parameter int CONTINUOUS    = 0,
    parameter int ENERGY_THRESH = 1024,
    localparam int LAG_W        = lag_w_f(MAX_LAG)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  trigger,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] left_data_in,
    input  logic [DATA_WIDTH-1:0] right_data_in,
    output logic [LED_W-1:0]      led_pattern,
    output logic [LAG_W-1:0]      best_lag,
    output logic                  beam_forming_valid,
    output logic                  busy,
    output logic                  sample_dropped,
    output logic                  silence
);

    localparam int ACC_W  = acc_w_f(DATA_WIDTH, FRAME_LEN);
    localparam int ADDR_W = clog2_f(FRAME_LEN);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int N_LAGS = 2 * MAX_LAG + 1;
    localparam int IDX_W  = (clog2_f(N_LAGS) > 0) ? clog2_f(N_LAGS) : 1;

    beam_state_e             state_q, state_d;
    logic [ADDR_W-1:0]       wr_q, wr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        lag_idx_q, lag_idx_d;
    logic signed [ACC_W-1:0] best_acc_q, best_acc_d;
    logic [IDX_W-1:0]        best_idx_q, best_idx_d;
    logic [LED_W-1:0]        led_q, led_d;
    logic [LAG_W-1:0]        best_lag_q, best_lag_d;
    logic                    valid_q, valid_d;
    logic                    dropped_q, dropped_d;

    logic [DATA_WIDTH-1:0]   l_buf_q [FRAME_LEN];
    logic [DATA_WIDTH-1:0]   r_buf_q [FRAME_LEN];

    logic                    capture_we;
    logic                    start_capture;
    logic                    mac_clear;
    logic                    mac_en;
    logic                    term_zero;
    logic [DATA_WIDTH-1:0]   mac_a;
    logic [DATA_WIDTH-1:0]   mac_b;
    logic signed [ACC_W-1:0] mac_acc;
    int                      j_idx;
    logic                    take_best;
    logic [IDX_W-1:0]        final_idx;
    logic [LED_W-1:0]        led_onehot;
    logic                    gate_silent;

    // Right-channel partner index n+k; out-of-frame partners contribute nothing.
    always_comb begin
        j_idx     = int'(cnt_q) + int'(lag_idx_q) - MAX_LAG;
        term_zero = (j_idx < 0) || (j_idx >= FRAME_LEN);
        mac_a     = l_buf_q[cnt_q[ADDR_W-1:0]];
        mac_b     = r_buf_q[j_idx[ADDR_W-1:0]];
    end

    beam_xcorr_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_W      (ACC_W)
    ) u_mac (
        .clk       (clk),
        .reset     (reset),
        .clear     (mac_clear),
        .enable    (mac_en),
        .zero_term (term_zero),
        .a         (mac_a),
        .b         (mac_b),
        .acc       (mac_acc)
    );

    // The first lag always seeds the best; afterwards only a strictly larger sum wins.
    assign take_best = (lag_idx_q == '0) || (mac_acc > best_acc_q);
    assign final_idx = take_best ? lag_idx_q : best_idx_q;

    for (genvar gi = 0; gi < LED_W; gi++) begin : g_onehot
        assign led_onehot[gi] = (int'(final_idx) == gi);
    end

    always_comb begin
        state_d       = state_q;
        wr_d          = wr_q;
        cnt_d         = cnt_q;
        lag_idx_d     = lag_idx_q;
        best_acc_d    = best_acc_q;
        best_idx_d    = best_idx_q;
        led_d         = led_q;
        best_lag_d    = best_lag_q;
        valid_d       = 1'b0;
        dropped_d     = sample_valid && (state_q != ST_CAPTURE);
        capture_we    = 1'b0;
        start_capture = 1'b0;
        mac_clear     = 1'b0;
        mac_en        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d       = ST_CAPTURE;
                    start_capture = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (sample_valid) begin
                    capture_we = 1'b1;
                    wr_d       = wr_q + 1'b1;
                    if (wr_q == ADDR_W'(FRAME_LEN - 1)) begin
                        state_d   = ST_CORR;
                        cnt_d     = '0;
                        lag_idx_d = '0;
                        mac_clear = 1'b1;
                    end
                end
            end
            ST_CORR: begin
                if (cnt_q == CNT_W'(FRAME_LEN)) begin
                    mac_clear = 1'b1;
                    cnt_d     = '0;
                    lag_idx_d = lag_idx_q + 1'b1;
                    if (take_best) begin
                        best_acc_d = mac_acc;
                        best_idx_d = lag_idx_q;
                    end
                end else begin
                    mac_en = 1'b1;
                    // The last lag's compare happens in DECIDE, keeping latency fixed.
                    if ((cnt_q == CNT_W'(FRAME_LEN - 1)) && (lag_idx_q == IDX_W'(N_LAGS - 1))) begin
                        state_d = ST_DECIDE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DECIDE: begin
                state_d = ST_DONE;
                valid_d = 1'b1;
                if (gate_silent) begin
                    led_d      = '0;
                    best_lag_d = '0;
                end else begin
                    led_d      = led_onehot;
                    best_lag_d = LAG_W'(int'(final_idx) - MAX_LAG);
                end
            end
            ST_DONE: begin
                if ((CONTINUOUS != 0) && trigger) begin
                    state_d       = ST_CAPTURE;
                    start_capture = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (start_capture) wr_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wr_q       <= '0;
            cnt_q      <= '0;
            lag_idx_q  <= '0;
            best_acc_q <= '0;
            best_idx_q <= '0;
            led_q      <= '0;
            best_lag_q <= '0;
            valid_q    <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
            lag_idx_q  <= lag_idx_d;
            best_acc_q <= best_acc_d;
            best_idx_q <= best_idx_d;
            led_q      <= led_d;
            best_lag_q <= best_lag_d;
            valid_q    <= valid_d;
            dropped_q  <= dropped_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                l_buf_q[i] <= '0;
                r_buf_q[i] <= '0;
            end
        end else if (capture_we) begin
            l_buf_q[wr_q] <= left_data_in;
            r_buf_q[wr_q] <= right_data_in;
        end
    end

`ifdef BEAM_ENERGY_GATE_EN
    logic [ACC_W-1:0]               energy_q, energy_d;
    logic signed [2*DATA_WIDTH-1:0] left_sq;
    logic                           silence_q, silence_d;

    always_comb begin
        left_sq  = $signed(left_data_in) * $signed(left_data_in);
        energy_d = energy_q;
        if (start_capture) begin
            energy_d = '0;
        end else if (capture_we) begin
            energy_d = energy_q + {{(ACC_W-2*DATA_WIDTH){1'b0}}, left_sq};
        end
        silence_d = silence_q;
        if (state_q == ST_DECIDE) silence_d = gate_silent;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            energy_q  <= '0;
            silence_q <= 1'b0;
        end else begin
            energy_q  <= energy_d;
            silence_q <= silence_d;
        end
    end

    assign gate_silent = (energy_q < ACC_W'(ENERGY_THRESH));
    assign silence     = silence_q;
`else
    logic unused_thresh;
    assign unused_thresh = (ENERGY_THRESH != 0);
    assign gate_silent   = 1'b0;
    assign silence       = 1'b0;
`endif

    assign led_pattern        = led_q;
    assign best_lag           = best_lag_q;
    assign beam_forming_valid = valid_q;
    assign sample_dropped     = dropped_q;
    assign busy               = (state_q == ST_CAPTURE) || (state_q == ST_CORR) || (state_q == ST_DECIDE);

endmodule
